// File: rtl/mem_dump_streamer.sv
// Reads COUNT words from a 1-cycle-latency memory and streams them MSB-first as bytes.
// Optional trailing two's-complement checksum byte when MEM_DUMP_CHECKSUM_EN is defined.
module mem_dump_streamer #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      base,
   input  logic [CNTW-1:0]  count,
   output logic             busy,
   output logic             done,
   output logic [31:0]      mem_addr,
   output logic [WIDTH-1:0] mem_in,
   output logic             mem_we,
   input  logic [WIDTH-1:0] mem_out,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready
);

   localparam int BPW  = WIDTH / 8;
   localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BPW - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_SEND,
`ifdef MEM_DUMP_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE
   } state_t;

   state_t           state, state_nx;
   logic [31:0]      addr;
   logic [31:0]      addr_last;
   logic [CNTW-1:0]  remaining;
   logic [IDXW-1:0]  idx;
   logic [WIDTH-1:0] shreg;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic [7:0]       sum;
`endif

   // Read-only initiator: the write side of the memory port is tied off.
   assign mem_in   = '0;
   assign mem_we   = 1'b0;
   assign mem_addr = (state == S_READ) ? addr : addr_last;

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (count == '0) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                  state_nx = S_CSUM;
`else
                  state_nx = S_DONE;
`endif
               end else begin
                  state_nx = S_READ;
               end
            end
         end
         S_READ: begin
            busy     = 1'b1;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            busy     = 1'b1;
            state_nx = S_SEND;
         end
         S_SEND: begin
            busy     = 1'b1;
            tx_valid = 1'b1;
            tx_data  = shreg[WIDTH-1 -: 8];
            if (tx_ready && (idx == LAST_IDX)) begin
               if (remaining == CNTW'(1)) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                  state_nx = S_CSUM;
`else
                  state_nx = S_DONE;
`endif
               end else begin
                  state_nx = S_READ;
               end
            end
         end
`ifdef MEM_DUMP_CHECKSUM_EN
         S_CSUM: begin
            busy     = 1'b1;
            tx_valid = 1'b1;
            tx_data  = ~sum + 8'd1;
            if (tx_ready) state_nx = S_DONE;
         end
`endif
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Control and counters; the remaining count is checked before its decrement.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         addr      <= '0;
         addr_last <= '0;
         remaining <= '0;
         idx       <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
         sum       <= '0;
`endif
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: begin
               if (start) begin
                  addr      <= base;
                  remaining <= count;
                  idx       <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
                  sum       <= '0;
`endif
               end
            end
            S_READ: addr_last <= addr;
            S_WAIT: idx <= '0;
            S_SEND: begin
               if (tx_ready) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                  sum <= sum + shreg[WIDTH-1 -: 8];
`endif
                  if (idx == LAST_IDX) begin
                     idx       <= '0;
                     addr      <= addr + 32'd1;
                     remaining <= remaining - 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Data path: only observed in SEND, so it needs no reset.
   always_ff @(posedge clk) begin
      if (state == S_WAIT) begin
         shreg <= mem_out;
      end else if ((state == S_SEND) && tx_ready) begin
         shreg <= shreg << 8;
      end
   end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer with a 1024-word registered-read memory model.
module tb_mem_dump_streamer;

   localparam int WIDTH = 32;
   localparam int CNTW  = 16;

   typedef logic [7:0] bq_t[$];

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [31:0]      base;
   logic [CNTW-1:0]  count;
   logic             busy;
   logic             done;
   logic [31:0]      mem_addr;
   logic [WIDTH-1:0] mem_in;
   logic             mem_we;
   logic [WIDTH-1:0] mem_out;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;

   int tests  = 0;
   int failed = 0;

   bq_t         cap;
   logic [31:0] addr_q[$];
   int          first_valid, done_cyc, done_cnt, we_bad, stall_bad, busy_bad;

   logic [31:0] mem [0:1023];

   mem_dump_streamer #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
      .busy(busy), .done(done), .mem_addr(mem_addr), .mem_in(mem_in),
      .mem_we(mem_we), .mem_out(mem_out), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_out <= mem[mem_addr[9:0]];

   function automatic int diff_at(input bq_t a, input bq_t b);
      int n = (a.size() < b.size()) ? a.size() : b.size();
      for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
      if (a.size() != b.size()) return n;
      return -1;
   endfunction

   function automatic logic [7:0] csum_of(input bq_t q);
      logic [7:0] s = 8'h00;
      foreach (q[i]) s = s + q[i];
      return ~s + 8'd1;
   endfunction

   task automatic do_start(input logic [31:0] b, input logic [CNTW-1:0] c);
      @(negedge clk);
      base     = b;
      count    = c;
      start    = 1'b1;
      tx_ready = 1'b1;
   endtask

   // Cycle 0 is the first cycle after the edge that samples start.
   task automatic run_xfer(input int max_cyc, input bit rnd_ready, input int inj_cyc);
      logic        stalled = 1'b0;
      logic [7:0]  pdata   = 8'h00;
      logic [31:0] la      = mem_addr;
      cap.delete();
      addr_q.delete();
      first_valid = -1; done_cyc = -1; done_cnt = 0;
      we_bad = 0; stall_bad = 0; busy_bad = 0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         start = (c == inj_cyc);
         if (c == inj_cyc) begin
            base  = 32'd100;
            count = 16'd3;
         end
         tx_ready = rnd_ready ? ($urandom_range(0, 2) == 0) : 1'b1;
         if (mem_we !== 1'b0 || mem_in !== '0) we_bad++;
         if (stalled && (tx_valid !== 1'b1 || tx_data !== pdata)) stall_bad++;
         if (mem_addr !== la) begin
            addr_q.push_back(mem_addr);
            la = mem_addr;
         end
         if (tx_valid === 1'b1 && first_valid < 0) first_valid = c;
         if (tx_valid === 1'b1 && tx_ready) cap.push_back(tx_data);
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
            if (busy !== 1'b0) busy_bad++;
         end else if (done_cyc < 0 && busy !== 1'b1) begin
            busy_bad++;
         end
         if (done_cyc >= 0 && c >= done_cyc + 2) break;
         stalled = tx_valid && !tx_ready;
         pdata   = tx_data;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; tx_ready = 1'b0; base = '0; count = '0;
      repeat (3) @(negedge clk);
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b want 0", done); end
      tests++; if (tx_valid !== 1'b0) begin failed++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      tests++; if (tx_data !== 8'h00) begin failed++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      tests++; if (mem_addr !== 32'h0) begin failed++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      tests++; if (mem_we !== 1'b0 || mem_in !== '0) begin failed++; $display("FAIL reset_mem_write: got we=%b in=%h want 0", mem_we, mem_in); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bq_t exp = '{8'h10, 8'h00, 8'h00, 8'h04, 8'h10, 8'h00, 8'h00, 8'h05};
      int  d;
      int  exp_done = 12;
`ifdef MEM_DUMP_CHECKSUM_EN
      exp.push_back(csum_of(exp));
      exp_done = 13;
`endif
      do_start(32'd4, 16'd2);
      run_xfer(60, 1'b0, -1);
      d = diff_at(cap, exp);
      tests++; if (d >= 0) begin failed++; $display("FAIL basic_bytes: diff at %0d, got %0d bytes want %0d", d, cap.size(), exp.size()); end
      tests++; if (first_valid != 2) begin failed++; $display("FAIL basic_latency: got %0d want 2", first_valid); end
      tests++; if (done_cyc != exp_done) begin failed++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, exp_done); end
      tests++; if (done_cnt != 1) begin failed++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
      tests++; if (busy_bad != 0) begin failed++; $display("FAIL basic_busy: got %0d bad cycles want 0", busy_bad); end
      tests++; if (we_bad != 0) begin failed++; $display("FAIL basic_mem_write: got %0d bad cycles want 0", we_bad); end
      tests++; if (addr_q.size() != 2 || addr_q[0] !== 32'd4 || addr_q[1] !== 32'd5) begin
         failed++; $display("FAIL basic_addr: got %0d addresses want 2 (4,5)", addr_q.size());
      end
   endtask

   task automatic test_backpressure();
      bq_t exp = '{8'h10, 8'h00, 8'h00, 8'h04, 8'h10, 8'h00, 8'h00, 8'h05};
      int  d;
`ifdef MEM_DUMP_CHECKSUM_EN
      exp.push_back(csum_of(exp));
`endif
      do_start(32'd4, 16'd2);
      run_xfer(400, 1'b1, -1);
      d = diff_at(cap, exp);
      tests++; if (d >= 0) begin failed++; $display("FAIL bp_bytes: diff at %0d, got %0d bytes want %0d", d, cap.size(), exp.size()); end
      tests++; if (stall_bad != 0) begin failed++; $display("FAIL bp_stall_hold: got %0d unstable cycles want 0", stall_bad); end
      tests++; if (done_cnt != 1) begin failed++; $display("FAIL bp_done_pulses: got %0d want 1", done_cnt); end
      tests++; if (we_bad != 0) begin failed++; $display("FAIL bp_mem_write: got %0d bad cycles want 0", we_bad); end
   endtask

   task automatic test_wrap();
      bq_t exp = '{8'h10, 8'h00, 8'h03, 8'hFF, 8'h10, 8'h00, 8'h00, 8'h00};
      int  d;
`ifdef MEM_DUMP_CHECKSUM_EN
      exp.push_back(csum_of(exp));
`endif
      do_start(32'hFFFF_FFFF, 16'd2);
      run_xfer(60, 1'b0, -1);
      d = diff_at(cap, exp);
      tests++; if (d >= 0) begin failed++; $display("FAIL wrap_bytes: diff at %0d, got %0d bytes want %0d", d, cap.size(), exp.size()); end
      tests++; if (addr_q.size() != 2 || addr_q[0] !== 32'hFFFF_FFFF || addr_q[1] !== 32'h0) begin
         failed++; $display("FAIL wrap_addr: got %0d addresses want 2 (ffffffff,0)", addr_q.size());
      end
      tests++; if (done_cnt != 1) begin failed++; $display("FAIL wrap_done_pulses: got %0d want 1", done_cnt); end
   endtask

   task automatic test_zero_count();
`ifdef MEM_DUMP_CHECKSUM_EN
      bq_t exp = '{8'h00};
      int  exp_done = 1;
`else
      bq_t exp = {};
      int  exp_done = 0;
`endif
      int d;
      do_start(32'd0, 16'd0);
      run_xfer(20, 1'b0, -1);
      d = diff_at(cap, exp);
      tests++; if (d >= 0) begin failed++; $display("FAIL zero_bytes: got %0d bytes want %0d", cap.size(), exp.size()); end
      tests++; if (done_cyc != exp_done) begin failed++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, exp_done); end
      tests++; if (done_cnt != 1) begin failed++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); end
   endtask

   task automatic test_start_ignored();
      bq_t exp = '{8'h10, 8'h00, 8'h00, 8'h04, 8'h10, 8'h00, 8'h00, 8'h05};
      int  d;
      int  exp_done = 12;
`ifdef MEM_DUMP_CHECKSUM_EN
      exp.push_back(csum_of(exp));
      exp_done = 13;
`endif
      do_start(32'd4, 16'd2);
      run_xfer(60, 1'b0, 5);
      d = diff_at(cap, exp);
      tests++; if (d >= 0) begin failed++; $display("FAIL ignore_bytes: diff at %0d, got %0d bytes want %0d", d, cap.size(), exp.size()); end
      tests++; if (done_cyc != exp_done) begin failed++; $display("FAIL ignore_done_cycle: got %0d want %0d", done_cyc, exp_done); end
      tests++; if (done_cnt != 1) begin failed++; $display("FAIL ignore_done_pulses: got %0d want 1", done_cnt); end
      tests++; if (addr_q.size() != 2 || addr_q[0] !== 32'd4 || addr_q[1] !== 32'd5) begin
         failed++; $display("FAIL ignore_addr: got %0d addresses want 2 (4,5)", addr_q.size());
      end
   endtask

   task automatic test_mid_reset();
      bq_t exp = '{8'h10, 8'h00, 8'h00, 8'h00};
      int  d;
      int  bad = 0;
`ifdef MEM_DUMP_CHECKSUM_EN
      exp.push_back(csum_of(exp));
`endif
      do_start(32'd4, 16'd2);
      repeat (5) begin
         @(negedge clk);
         start = 1'b0;
      end
      tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
         failed++; $display("FAIL mrst_third_byte: got valid=%b data=%h want 1/00", tx_valid, tx_data);
      end
      rst = 1'b1;
      @(negedge clk);
      tests++; if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failed++; $display("FAIL mrst_outputs: got valid=%b busy=%b done=%b want 0/0/0", tx_valid, busy, done);
      end
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      tests++; if (bad != 0) begin failed++; $display("FAIL mrst_quiet: got %0d active cycles want 0", bad); end
      do_start(32'd0, 16'd1);
      run_xfer(40, 1'b0, -1);
      d = diff_at(cap, exp);
      tests++; if (d >= 0) begin failed++; $display("FAIL mrst_restart_bytes: diff at %0d, got %0d bytes want %0d", d, cap.size(), exp.size()); end
      tests++; if (done_cnt != 1) begin failed++; $display("FAIL mrst_restart_done: got %0d want 1", done_cnt); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_count();
      test_start_ignored();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
